// File: rtl/tilemap_writer.sv
// tilemap_writer: owns the background tile-ID map. Edit commands from game
// logic are queued in a small FIFO and applied one cell per clock, but only
// while vblank is high, so the renderer never sees a map change mid-frame.
module tilemap_writer #(
   parameter int NUM_TILES_X       = 40,
   parameter int NUM_TILES_Y       = 25,
   parameter int ADDR_TILES_X_SIZE = 6,
   parameter int ADDR_TILES_Y_SIZE = 5,
   parameter int TILE_IDX_WIDTH    = 5,
   parameter int FIFO_DEPTH        = 8,
   parameter int RESET_TILE        = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [1:0]                   cmd_op,
   input  logic [ADDR_TILES_X_SIZE-1:0] cmd_x,
   input  logic [ADDR_TILES_Y_SIZE-1:0] cmd_y,
   input  logic [TILE_IDX_WIDTH-1:0]    cmd_id,
   input  logic                         vblank,
   output logic [TILE_IDX_WIDTH-1:0]    tilemap [0:NUM_TILES_Y-1][0:NUM_TILES_X-1],
   output logic                         busy,
   output logic                         err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Limits are one bit wider than the coordinate so a map dimension equal
   // to a power of two still compares correctly.
   localparam logic [ADDR_TILES_X_SIZE:0]   X_LIM  = (ADDR_TILES_X_SIZE+1)'(NUM_TILES_X);
   localparam logic [ADDR_TILES_Y_SIZE:0]   Y_LIM  = (ADDR_TILES_Y_SIZE+1)'(NUM_TILES_Y);
   localparam logic [ADDR_TILES_X_SIZE-1:0] X_LAST = ADDR_TILES_X_SIZE'(NUM_TILES_X-1);
   localparam logic [ADDR_TILES_Y_SIZE-1:0] Y_LAST = ADDR_TILES_Y_SIZE'(NUM_TILES_Y-1);
   localparam logic [CNT_W-1:0]             FULL_CNT = CNT_W'(FIFO_DEPTH);

   localparam logic [1:0] OP_CELL = 2'b00;
   localparam logic [1:0] OP_ROW  = 2'b01;
   localparam logic [1:0] OP_COL  = 2'b10;
   localparam logic [1:0] OP_MAP  = 2'b11;

   typedef enum logic {IDLE, EXEC} state_t;

   // Command FIFO storage (data only, no reset needed)
   logic [1:0]                   fifo_op_q [0:FIFO_DEPTH-1];
   logic [ADDR_TILES_X_SIZE-1:0] fifo_x_q  [0:FIFO_DEPTH-1];
   logic [ADDR_TILES_Y_SIZE-1:0] fifo_y_q  [0:FIFO_DEPTH-1];
   logic [TILE_IDX_WIDTH-1:0]    fifo_id_q [0:FIFO_DEPTH-1];

   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;

   state_t                       state_q, state_d;
   logic [1:0]                   op_q, op_d;
   logic [TILE_IDX_WIDTH-1:0]    id_q, id_d;
   logic [ADDR_TILES_X_SIZE-1:0] cur_x_q, cur_x_d;
   logic [ADDR_TILES_Y_SIZE-1:0] cur_y_q, cur_y_d;
   logic                         err_q, err_d;

   logic [TILE_IDX_WIDTH-1:0]    map_q [0:NUM_TILES_Y-1][0:NUM_TILES_X-1];

   logic                         full, empty, push, pop, wr_en, head_ok;
   logic [1:0]                   head_op;
   logic [ADDR_TILES_X_SIZE-1:0] head_x;
   logic [ADDR_TILES_Y_SIZE-1:0] head_y;
   logic [TILE_IDX_WIDTH-1:0]    head_id;

   assign full      = (count_q == FULL_CNT);
   assign empty     = (count_q == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;

   assign head_op = fifo_op_q[rd_ptr_q];
   assign head_x  = fifo_x_q[rd_ptr_q];
   assign head_y  = fifo_y_q[rd_ptr_q];
   assign head_id = fifo_id_q[rd_ptr_q];

   assign tilemap = map_q;
   assign busy    = !empty || (state_q == EXEC);
   assign err     = err_q;

   // Range check of the FIFO head; only the coordinates the op uses matter
   always_comb begin
      head_ok = 1'b1;
      case (head_op)
         OP_CELL: head_ok = ({1'b0, head_x} < X_LIM) && ({1'b0, head_y} < Y_LIM);
         OP_ROW:  head_ok = ({1'b0, head_y} < Y_LIM);
         OP_COL:  head_ok = ({1'b0, head_x} < X_LIM);
         default: head_ok = 1'b1;
      endcase
   end

   // Store pushed commands at the write pointer
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op_q[wr_ptr_q] <= cmd_op;
         fifo_x_q[wr_ptr_q]  <= cmd_x;
         fifo_y_q[wr_ptr_q]  <= cmd_y;
         fifo_id_q[wr_ptr_q] <= cmd_id;
      end
   end

   // FIFO occupancy: a simultaneous push and pop leaves it unchanged
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // Next state: pop and range-check in IDLE, walk the target cells in EXEC
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      id_d    = id_q;
      cur_x_d = cur_x_q;
      cur_y_d = cur_y_q;
      pop     = 1'b0;
      err_d   = 1'b0;
      wr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (vblank && !empty) begin
               pop = 1'b1;
               if (head_ok) begin
                  op_d    = head_op;
                  id_d    = head_id;
                  state_d = EXEC;
                  case (head_op)
                     OP_CELL: begin cur_x_d = head_x; cur_y_d = head_y; end
                     OP_ROW:  begin cur_x_d = '0;     cur_y_d = head_y; end
                     OP_COL:  begin cur_x_d = head_x; cur_y_d = '0;     end
                     default: begin cur_x_d = '0;     cur_y_d = '0;     end
                  endcase
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         EXEC: begin
            // With vblank low the walk simply holds its position
            if (vblank) begin
               wr_en = 1'b1;
               case (op_q)
                  OP_CELL: state_d = IDLE;
                  OP_ROW: begin
                     if (cur_x_q == X_LAST) state_d = IDLE;
                     else                   cur_x_d = cur_x_q + 1'b1;
                  end
                  OP_COL: begin
                     if (cur_y_q == Y_LAST) state_d = IDLE;
                     else                   cur_y_d = cur_y_q + 1'b1;
                  end
                  default: begin
                     if (cur_x_q == X_LAST) begin
                        cur_x_d = '0;
                        if (cur_y_q == Y_LAST) state_d = IDLE;
                        else                   cur_y_d = cur_y_q + 1'b1;
                     end else begin
                        cur_x_d = cur_x_q + 1'b1;
                     end
                  end
               endcase
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM and active-command registers; reset aborts any fill in progress
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         op_q    <= OP_CELL;
         id_q    <= '0;
         cur_x_q <= '0;
         cur_y_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         id_q    <= id_d;
         cur_x_q <= cur_x_d;
         cur_y_q <= cur_y_d;
         err_q   <= err_d;
      end
   end

   // Tile map register array: one cell written per executing cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int yy = 0; yy < NUM_TILES_Y; yy++) begin
            for (int xx = 0; xx < NUM_TILES_X; xx++) begin
               map_q[yy][xx] <= TILE_IDX_WIDTH'(RESET_TILE);
            end
         end
      end else if (wr_en) begin
         map_q[cur_y_q][cur_x_q] <= id_q;
      end
   end

endmodule
